// File: rtl/imem_port_arbiter_if.sv
// Request, response and imem-port signals shared between the arbiter and its environment.
// The master side is the environment (both requesters, the consumer and the imem itself).
interface imem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             r0_valid;
    logic [WIDTH-1:0] r0_addr;
    logic             r0_ready;
    logic             r1_valid;
    logic [WIDTH-1:0] r1_addr;
    logic             r1_ready;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             rsp_ready;
    logic [WIDTH-1:0] mem_a;
    logic [WIDTH-1:0] mem_rd;

    modport master (
        output r0_valid, r0_addr, r1_valid, r1_addr, rsp_ready, mem_rd,
        input  r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mem_a
    );

    modport slave (
        input  r0_valid, r0_addr, r1_valid, r1_addr, rsp_ready, mem_rd,
        output r0_ready, r1_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mem_a
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin sharing of the combinational imem read port between fetch (0) and debug (1),
// with a single registered response slot that holds under backpressure.
module imem_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64
) (
    input logic                clk,
    input logic                reset,
    imem_port_arbiter_if.slave bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(4 * SIZE);

    slot_state_t      state_reg, state_next;
    logic             rsp_id_reg, rsp_id_next;
    logic [WIDTH-1:0] rsp_data_reg, rsp_data_next;
    logic             rsp_err_reg, rsp_err_next;
    logic             last_grant_reg, last_grant_next;

    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_addr [2];
    logic [1:0]       req_ready;
    logic             can_issue;
    logic             grant_valid;
    logic             grant_id;
    logic [WIDTH-1:0] grant_addr;
    logic             addr_err;

    assign req_valid   = {bus.r1_valid, bus.r0_valid};
    assign req_addr[0] = bus.r0_addr;
    assign req_addr[1] = bus.r1_addr;

    // A slot being drained this cycle can be refilled in the same cycle.
    assign can_issue = (state_reg == EMPTY) || bus.rsp_ready;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!reset && can_issue) begin
            case (req_valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_id    = ~last_grant_reg;
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_id    = 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_valid && (grant_id == 1'(gi));
        end
    endgenerate

    // With no grant the port still sees a defined address (requester 0's).
    assign grant_addr = grant_valid ? req_addr[grant_id] : bus.r0_addr;
    assign addr_err   = (grant_addr[1:0] != 2'b00) || (grant_addr >= ADDR_LIMIT);

    always_comb begin
        state_next      = state_reg;
        rsp_id_next     = rsp_id_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_err_next    = rsp_err_reg;
        last_grant_next = last_grant_reg;
        if (grant_valid) begin
            state_next      = FULL;
            rsp_id_next     = grant_id;
            rsp_err_next    = addr_err;
            rsp_data_next   = addr_err ? '0 : bus.mem_rd;
            last_grant_next = grant_id;
        end else if ((state_reg == FULL) && bus.rsp_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= EMPTY;
            rsp_id_reg     <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign bus.r0_ready  = req_ready[0];
    assign bus.r1_ready  = req_ready[1];
    assign bus.mem_a     = grant_addr;
    assign bus.rsp_valid = (state_reg == FULL);
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed vector table for the arbiter followed by a randomized run against a reference model.
module tb_imem_port_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    imem_port_arbiter_if #(.WIDTH(32)) bus ();

    imem_port_arbiter #(.WIDTH(32), .SIZE(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] imem [0:63];
    assign bus.mem_rd = imem[bus.mem_a[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        r0v;
        logic [31:0] r0a;
        logic        r1v;
        logic [31:0] r1a;
        logic        rr;
        logic        e0;
        logic        e1;
        logic        ev;
        logic        chk;
        logic        eid;
        logic [31:0] edata;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic r0v, input logic [31:0] r0a,
                                input logic r1v, input logic [31:0] r1a, input logic rr,
                                input logic e0, input logic e1, input logic ev, input logic chk,
                                input logic eid, input logic [31:0] edata, input logic eerr);
        vec_t v;
        v.rst = rst; v.r0v = r0v; v.r0a = r0a; v.r1v = r1v; v.r1a = r1a; v.rr = rr;
        v.e0 = e0; v.e1 = e1; v.ev = ev; v.chk = chk; v.eid = eid; v.edata = edata; v.eerr = eerr;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic r0v, input logic [31:0] r0a,
                         input logic r1v, input logic [31:0] r1a, input logic rr);
        reset         = rst;
        bus.r0_valid  = r0v;
        bus.r0_addr   = r0a;
        bus.r1_valid  = r1v;
        bus.r1_addr   = r1a;
        bus.rsp_ready = rr;
    endtask

    function automatic logic ref_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] a);
        return ref_err(a) ? 32'h0 : 32'h1000_0000 + a / 4;
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'($urandom_range(0, 255));
        if (sel == 1) return 32'(4 * $urandom_range(64, 300));
        return 32'(4 * $urandom_range(0, 63));
    endfunction

    // Reference model state: contents of the response slot and who was served last.
    logic        m_valid;
    logic        m_id;
    logic [31:0] m_data;
    logic        m_err;
    int          m_last;

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 64; k++) imem[k] = 32'h1000_0000 + 32'(k);

        // rst r0v r0a r1v r1a rr | e0 e1 ev chk eid edata err
        vecs.push_back(mk(1, 1, 32'h00, 1, 32'h20, 1, 0, 0, 0, 1, 0, 32'h0, 0));
        vecs.push_back(mk(1, 1, 32'h00, 1, 32'h20, 1, 0, 0, 0, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h00, 1, 32'h20, 1, 1, 0, 0, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h04, 0, 32'h00, 1, 1, 0, 1, 1, 0, 32'h1000_0000, 0));
        vecs.push_back(mk(0, 1, 32'h08, 0, 32'h00, 1, 1, 0, 1, 1, 0, 32'h1000_0001, 0));
        vecs.push_back(mk(0, 0, 32'h00, 0, 32'h00, 1, 0, 0, 1, 1, 0, 32'h1000_0002, 0));
        // round robin: last winner was 0, so 1 goes first
        vecs.push_back(mk(0, 1, 32'h10, 1, 32'h20, 1, 0, 1, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h10, 1, 32'h20, 1, 1, 0, 1, 1, 1, 32'h1000_0008, 0));
        vecs.push_back(mk(0, 1, 32'h10, 1, 32'h20, 1, 0, 1, 1, 1, 0, 32'h1000_0004, 0));
        vecs.push_back(mk(0, 1, 32'h10, 1, 32'h20, 1, 1, 0, 1, 1, 1, 32'h1000_0008, 0));
        vecs.push_back(mk(0, 0, 32'h00, 1, 32'hFC, 1, 0, 1, 1, 1, 0, 32'h1000_0004, 0));
        // backpressure for three cycles, then drain and refill together
        vecs.push_back(mk(0, 1, 32'h00, 0, 32'h00, 0, 0, 0, 1, 1, 1, 32'h1000_003F, 0));
        vecs.push_back(mk(0, 1, 32'h00, 0, 32'h00, 0, 0, 0, 1, 1, 1, 32'h1000_003F, 0));
        vecs.push_back(mk(0, 1, 32'h00, 0, 32'h00, 0, 0, 0, 1, 1, 1, 32'h1000_003F, 0));
        vecs.push_back(mk(0, 1, 32'h00, 0, 32'h00, 1, 1, 0, 1, 1, 1, 32'h1000_003F, 0));
        // error addresses
        vecs.push_back(mk(0, 1, 32'h102, 0, 32'h00, 1, 1, 0, 1, 1, 0, 32'h1000_0000, 0));
        vecs.push_back(mk(0, 0, 32'h00, 1, 32'h100, 1, 0, 1, 1, 1, 0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 32'h00, 0, 32'h00, 1, 1, 0, 1, 1, 1, 32'h0, 1));
        vecs.push_back(mk(0, 0, 32'h00, 0, 32'h00, 0, 0, 0, 1, 1, 0, 32'h1000_0000, 0));
        // reset while full and stalled
        vecs.push_back(mk(1, 1, 32'h04, 1, 32'h08, 0, 0, 0, 1, 1, 0, 32'h1000_0000, 0));
        vecs.push_back(mk(0, 1, 32'h04, 1, 32'h08, 0, 1, 0, 0, 1, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 32'h04, 1, 32'h08, 0, 0, 0, 1, 1, 0, 32'h1000_0001, 0));

        drive(1, 0, 32'h0, 0, 32'h0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].r0v, vecs[i].r0a, vecs[i].r1v, vecs[i].r1a, vecs[i].rr);
            #1;
            check("r0_ready", i, 32'(bus.r0_ready), 32'(vecs[i].e0));
            check("r1_ready", i, 32'(bus.r1_ready), 32'(vecs[i].e1));
            check("rsp_valid", i, 32'(bus.rsp_valid), 32'(vecs[i].ev));
            if (vecs[i].chk) begin
                check("rsp_id", i, 32'(bus.rsp_id), 32'(vecs[i].eid));
                check("rsp_data", i, bus.rsp_data, vecs[i].edata);
                check("rsp_err", i, 32'(bus.rsp_err), 32'(vecs[i].eerr));
            end
            $display("vec %0d: r0v=%0d r1v=%0d rr=%0d -> r0_ready=%0d r1_ready=%0d rsp_valid=%0d id=%0d data=%h err=%0d",
                     i, vecs[i].r0v, vecs[i].r1v, vecs[i].rr, bus.r0_ready, bus.r1_ready,
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
            @(posedge clk);
            #1;
        end

        // Randomized phase: start from a clean reset so the model is in step.
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_id = 1'b0; m_data = 32'h0; m_err = 1'b0; m_last = 1;

        for (int n = 0; n < 400; n++) begin
            logic        rst;
            logic        rr;
            logic        want [2];
            logic [31:0] addr [2];
            logic        can;
            int          winner;
            logic [31:0] exp_a;

            rst     = ($urandom_range(0, 99) < 3);
            want[0] = 1'($urandom_range(0, 1));
            want[1] = 1'($urandom_range(0, 1));
            addr[0] = rand_addr();
            addr[1] = rand_addr();
            rr      = ($urandom_range(0, 3) != 0);
            drive(rst, want[0], addr[0], want[1], addr[1], rr);
            #1;

            // The requester after the last one served gets first pick.
            winner = -1;
            can    = !m_valid || rr;
            if (!rst && can) begin
                for (int k = 0; k < 2; k++) begin
                    int c;
                    c = (m_last + 1 + k) % 2;
                    if (winner < 0 && want[c]) winner = c;
                end
            end
            exp_a = (winner >= 0) ? addr[winner] : addr[0];

            check("rand_r0_ready", n, 32'(bus.r0_ready), 32'(winner == 0));
            check("rand_r1_ready", n, 32'(bus.r1_ready), 32'(winner == 1));
            check("rand_mem_a", n, bus.mem_a, exp_a);
            check("rand_rsp_valid", n, 32'(bus.rsp_valid), 32'(m_valid));
            if (m_valid) begin
                check("rand_rsp_id", n, 32'(bus.rsp_id), 32'(m_id));
                check("rand_rsp_data", n, bus.rsp_data, m_data);
                check("rand_rsp_err", n, 32'(bus.rsp_err), 32'(m_err));
            end
            $display("rand %0d: rst=%0d want=%0d%0d rr=%0d winner=%0d rsp_valid=%0d data=%h",
                     n, rst, want[1], want[0], rr, winner, bus.rsp_valid, bus.rsp_data);

            @(posedge clk);
            #1;
            if (rst) begin
                m_valid = 1'b0; m_id = 1'b0; m_data = 32'h0; m_err = 1'b0; m_last = 1;
            end else if (winner >= 0) begin
                m_valid = 1'b1;
                m_id    = 1'(winner);
                m_err   = ref_err(addr[winner]);
                m_data  = ref_data(addr[winner]);
                m_last  = winner;
            end else if (m_valid && rr) begin
                m_valid = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
